pf_lift_ctrl: RTL



---
 rtl/pf_pkg.sv | 46 ++++
 rtl/pf_axis.sv | 79 +++++++
 rtl/pf_lift_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/pf_pkg.sv
// Shared types, constants and saturating helpers for the moving-platform controller.
package pf_pkg;

    localparam int unsigned OFS_W  = 10;
    localparam int unsigned HOLD_W = 6;
    localparam int unsigned DEB_W  = 2;
    localparam int unsigned N_BTN  = 4;
    localparam int unsigned N_PF   = 2;

    localparam logic [OFS_W-1:0]  STEP        = 10'd2;
    localparam logic [OFS_W-1:0]  RET_STEP    = 10'd1;
    localparam logic [OFS_W-1:0]  MAX_TRAVEL  = 10'd48;
    localparam logic [HOLD_W-1:0] HOLD_FRAMES = 6'd60;
    localparam logic [DEB_W-1:0]  DEB_FRAMES  = 2'd2;
    localparam logic [OFS_W-1:0]  PF_W        = 10'd48;
    localparam logic [OFS_W-1:0]  PF_H        = 10'd16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        HOLD    = 2'd2,
        RETURN  = 2'd3
    } pf_state_t;

    // Add one bit wider than the offset, then clamp to lim so the sum can never wrap.
    function automatic logic [OFS_W-1:0] sat_add(
        input logic [OFS_W-1:0] a,
        input logic [OFS_W-1:0] b,
        input logic [OFS_W-1:0] lim
    );
        logic [OFS_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[OFS_W-1:0];
    endfunction

    // Subtract one bit wider than the offset; a borrow means the result floors at zero.
    function automatic logic [OFS_W-1:0] sat_sub(
        input logic [OFS_W-1:0] a,
        input logic [OFS_W-1:0] b
    );
        logic [OFS_W:0] s;
        s = {1'b0, a} - {1'b0, b};
        return s[OFS_W] ? '0 : s[OFS_W-1:0];
    endfunction

endpackage

// File: rtl/pf_axis.sv
// Single-platform vertical motion: FSM, offset register and post-release hold timer.
module pf_axis
    import pf_pkg::*;
(
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             req,
    output logic [OFS_W-1:0] offset,
    output logic             moving,
    output logic             at_max
);

    pf_state_t         state;
    pf_state_t         state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [OFS_W-1:0]  offset_nxt;
    logic              moving_nxt;
    logic              at_max_nxt;

    // State register; offset and flags are registered together so they always agree.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            offset   <= '0;
            moving   <= 1'b0;
            at_max   <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            offset   <= offset_nxt;
            moving   <= moving_nxt;
            at_max   <= at_max_nxt;
        end
    end

    // Next-state: a request always wins, so a reversal out of RETURN costs no frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) state_nxt = ADVANCE;
            end
            ADVANCE: begin
                if (!req) state_nxt = HOLD;
            end
            HOLD: begin
                if (req)
                    state_nxt = ADVANCE;
                else if (hold_cnt == HOLD_W'(HOLD_FRAMES - 6'd1))
                    state_nxt = RETURN;
            end
            RETURN: begin
                if (req)
                    state_nxt = ADVANCE;
                else if (offset <= RET_STEP)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath keyed on the state being entered, so motion starts on the transition edge.
    always_comb begin
        offset_nxt = offset;
        hold_nxt   = '0;
        case (state_nxt)
            IDLE:    offset_nxt = '0;
            ADVANCE: offset_nxt = sat_add(offset, STEP, MAX_TRAVEL);
            HOLD:    hold_nxt   = (state == HOLD) ? HOLD_W'(hold_cnt + 6'd1) : '0;
            RETURN:  offset_nxt = sat_sub(offset, RET_STEP);
            default: offset_nxt = '0;
        endcase
        moving_nxt = (state_nxt == ADVANCE) || (state_nxt == RETURN);
        at_max_nxt = (offset_nxt == MAX_TRAVEL);
    end

endmodule

// File: rtl/pf_lift_ctrl.sv
// Two-platform lift controller: button debounce, per-platform motion, fixed base positions.
module pf_lift_ctrl
    import pf_pkg::*;
#(
    parameter logic [OFS_W-1:0] PF0_X = 10'd160,
    parameter logic [OFS_W-1:0] PF0_Y = 10'd240,
    parameter logic [OFS_W-1:0] PF1_X = 10'd400,
    parameter logic [OFS_W-1:0] PF1_Y = 10'd176
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] buttonOn,
    output logic [OFS_W-1:0] buttonMotion [N_PF],
    output logic [OFS_W-1:0] pfX          [N_PF],
    output logic [OFS_W-1:0] pfY          [N_PF],
    output logic [N_PF-1:0]  pf_moving,
    output logic [N_PF-1:0]  pf_at_max
);

    logic [DEB_W-1:0] deb_cnt [N_BTN];
    logic [N_BTN-1:0] pressed;
    logic [N_PF-1:0]  req;

    // Per-button saturating debounce counters; any low frame clears the count.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(N_BTN); i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                if (!buttonOn[i])
                    deb_cnt[i] <= '0;
                else if (deb_cnt[i] < DEB_FRAMES)
                    deb_cnt[i] <= DEB_W'(deb_cnt[i] + 2'd1);
            end
        end
    end

    // A button counts once it has been seen high for DEB_FRAMES frames.
    always_comb begin
        pressed = '0;
        for (int i = 0; i < int'(N_BTN); i++) pressed[i] = (deb_cnt[i] >= DEB_FRAMES);
    end

    // Either button of a pair raises that platform's request.
    always_comb begin
        req[0] = pressed[0] | pressed[1];
        req[1] = pressed[2] | pressed[3];
    end

    // Base positions are fixed and independent of reset.
    always_comb begin
        pfX[0] = PF0_X;
        pfY[0] = PF0_Y;
        pfX[1] = PF1_X;
        pfY[1] = PF1_Y;
    end

    pf_axis u_axis0 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .req       (req[0]),
        .offset    (buttonMotion[0]),
        .moving    (pf_moving[0]),
        .at_max    (pf_at_max[0])
    );

    pf_axis u_axis1 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .req       (req[1]),
        .offset    (buttonMotion[1]),
        .moving    (pf_moving[1]),
        .at_max    (pf_at_max[1])
    );

endmodule
